// File: rtl/wb_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_reg_arbiter_if
//
// One Wishbone channel as used between a register-bank master and the shared
// register-bank slave port. The same interface type is used for the two master
// channels and for the slave channel of wb_reg_arbiter.
//
// Signals (direction given for the master modport):
//   adr       out  ADDRWIDTH  address
//   cyc       out  1          bus cycle
//   stb       out  1          strobe
//   we        out  1          write enable
//   byte_stb  out  4          byte enables
//   dat_w     out  DATAWIDTH  write data (master to slave)
//   dat_r     in   DATAWIDTH  read data (slave to master)
//   ack       in   1          acknowledge
// -----------------------------------------------------------------------------
interface wb_reg_arbiter_if #(
    parameter int unsigned ADDRWIDTH = 7,
    parameter int unsigned DATAWIDTH = 32
);
    logic [ADDRWIDTH-1:0] adr;
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [3:0]           byte_stb;
    logic [DATAWIDTH-1:0] dat_w;
    logic [DATAWIDTH-1:0] dat_r;
    logic                 ack;

    modport master (
        output adr, cyc, stb, we, byte_stb, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  adr, cyc, stb, we, byte_stb, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// wb_reg_arbiter
//
// Two-master Wishbone arbiter in front of the FPGA register bank. Master 0 is
// the AHB-to-FPGA bridge, master 1 the FPGA-side sequencer. One transfer is
// granted at a time; simultaneous requests are resolved round-robin.
//
// Optional feature (macro WB_REG_ARB_TIMEOUT_EN): a watchdog that terminates a
// granted transfer the slave never acknowledges, returning ERR_VALUE to the
// master with an ACK and pulsing Timeout_o. Without the macro a grant waits
// indefinitely for the slave ACK or a master abort, and Timeout_o is tied 0.
//
// Ports:
//   WBs_CLK_i   in   1   clock
//   WBs_RST_i   in   1   asynchronous active-high reset
//   m0_bus      wb_reg_arbiter_if.slave   master 0 channel
//   m1_bus      wb_reg_arbiter_if.slave   master 1 channel
//   s_bus       wb_reg_arbiter_if.master  register-bank slave channel
//   Grant_o     out  2   one-hot current grant, 2'b00 when idle
//   Timeout_o   out  1   one-cycle pulse on a watchdog termination
//
// Parameters:
//   ADDRWIDTH, DATAWIDTH  bus widths (must match the interface instances)
//   TIMEOUT_CYC           granted cycles without ACK before the watchdog fires
//   ERR_VALUE             read data returned on a watchdog termination
// -----------------------------------------------------------------------------
module wb_reg_arbiter #(
    parameter int unsigned          ADDRWIDTH   = 7,
    parameter int unsigned          DATAWIDTH   = 32,
    parameter logic [7:0]           TIMEOUT_CYC = 8'd255,
    parameter logic [DATAWIDTH-1:0] ERR_VALUE   = 32'hDEAD_DEAD
) (
    input  logic                    WBs_CLK_i,
    input  logic                    WBs_RST_i,
    wb_reg_arbiter_if.slave         m0_bus,
    wb_reg_arbiter_if.slave         m1_bus,
    wb_reg_arbiter_if.master        s_bus,
    output logic [1:0]              Grant_o,
    output logic                    Timeout_o
);

    // State encoding is one-hot on the grant so a decoded grant is trivial.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   last_gnt_q;      // master granted most recently (1 after reset)
    logic   last_gnt_d;

    logic   req0_s;
    logic   req1_s;
    logic   sel_cyc_s;       // CYC of the currently granted master
    logic   timeout_fire_s;  // watchdog terminates the current transfer
    logic   xfer_end_s;      // current grant finishes this cycle

    logic [ADDRWIDTH-1:0] s_adr_s;
    logic                 s_cyc_s;
    logic                 s_stb_s;
    logic                 s_we_s;
    logic [3:0]           s_byte_stb_s;
    logic [DATAWIDTH-1:0] s_dat_s;
    logic                 m0_ack_s;
    logic [DATAWIDTH-1:0] m0_dat_s;
    logic                 m1_ack_s;
    logic [DATAWIDTH-1:0] m1_dat_s;

    assign req0_s = m0_bus.cyc & m0_bus.stb;
    assign req1_s = m1_bus.cyc & m1_bus.stb;

    // Select the CYC line of whichever master currently holds the grant.
    always_comb begin
        sel_cyc_s = 1'b0;
        case (state_q)
            ST_GNT0: sel_cyc_s = m0_bus.cyc;
            ST_GNT1: sel_cyc_s = m1_bus.cyc;
            default: sel_cyc_s = 1'b0;
        endcase
    end

`ifdef WB_REG_ARB_TIMEOUT_EN
    logic [7:0] wdog_q;
    logic [7:0] wdog_d;

    // Watchdog count: held at zero while idle so every grant starts from 0,
    // then counts granted cycles that see no slave ACK.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_IDLE) begin
            wdog_d = 8'd0;
        end else if (!s_bus.ack) begin
            wdog_d = wdog_q + 8'd1;
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // Fires on the TIMEOUT_CYC-th granted cycle; a coincident slave ACK wins,
    // and a master that has already dropped CYC is treated as an abort.
    assign timeout_fire_s = (state_q != ST_IDLE) & sel_cyc_s & ~s_bus.ack
                          & (wdog_q == (TIMEOUT_CYC - 8'd1));
`else
    assign timeout_fire_s = 1'b0;
`endif

    assign xfer_end_s = s_bus.ack | ~sel_cyc_s | timeout_fire_s;

    // State register and round-robin pointer.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, release the grant after one
    // transfer (ACK), an abort (CYC low) or a watchdog termination.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_s && req1_s) begin
                    // Tie: the master not served last goes first.
                    if (last_gnt_q) begin
                        state_d = ST_GNT0;
                    end else begin
                        state_d = ST_GNT1;
                    end
                end else if (req0_s) begin
                    state_d = ST_GNT0;
                end else if (req1_s) begin
                    state_d = ST_GNT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (xfer_end_s) begin
                    state_d    = ST_IDLE;
                    last_gnt_d = 1'b0;
                end else begin
                    state_d    = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (xfer_end_s) begin
                    state_d    = ST_IDLE;
                    last_gnt_d = 1'b1;
                end else begin
                    state_d    = ST_GNT1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                last_gnt_d = last_gnt_q;
            end
        endcase
    end

    // Output routing: the granted master is connected straight through to the
    // slave; everything else is held at zero. A watchdog termination drops
    // the slave request and hands the master an ACK carrying ERR_VALUE.
    always_comb begin
        s_adr_s      = '0;
        s_cyc_s      = 1'b0;
        s_stb_s      = 1'b0;
        s_we_s       = 1'b0;
        s_byte_stb_s = 4'h0;
        s_dat_s      = '0;
        m0_ack_s     = 1'b0;
        m0_dat_s     = '0;
        m1_ack_s     = 1'b0;
        m1_dat_s     = '0;
        case (state_q)
            ST_GNT0: begin
                s_adr_s      = m0_bus.adr;
                s_cyc_s      = m0_bus.cyc & ~timeout_fire_s;
                s_stb_s      = m0_bus.stb & ~timeout_fire_s;
                s_we_s       = m0_bus.we;
                s_byte_stb_s = m0_bus.byte_stb;
                s_dat_s      = m0_bus.dat_w;
                m0_ack_s     = s_bus.ack | timeout_fire_s;
                m0_dat_s     = timeout_fire_s ? ERR_VALUE : s_bus.dat_r;
            end
            ST_GNT1: begin
                s_adr_s      = m1_bus.adr;
                s_cyc_s      = m1_bus.cyc & ~timeout_fire_s;
                s_stb_s      = m1_bus.stb & ~timeout_fire_s;
                s_we_s       = m1_bus.we;
                s_byte_stb_s = m1_bus.byte_stb;
                s_dat_s      = m1_bus.dat_w;
                m1_ack_s     = s_bus.ack | timeout_fire_s;
                m1_dat_s     = timeout_fire_s ? ERR_VALUE : s_bus.dat_r;
            end
            default: begin
                s_adr_s      = '0;
                s_cyc_s      = 1'b0;
                s_stb_s      = 1'b0;
                s_we_s       = 1'b0;
                s_byte_stb_s = 4'h0;
                s_dat_s      = '0;
                m0_ack_s     = 1'b0;
                m0_dat_s     = '0;
                m1_ack_s     = 1'b0;
                m1_dat_s     = '0;
            end
        endcase
    end

    assign s_bus.adr      = s_adr_s;
    assign s_bus.cyc      = s_cyc_s;
    assign s_bus.stb      = s_stb_s;
    assign s_bus.we       = s_we_s;
    assign s_bus.byte_stb = s_byte_stb_s;
    assign s_bus.dat_w    = s_dat_s;

    assign m0_bus.ack     = m0_ack_s;
    assign m0_bus.dat_r   = m0_dat_s;
    assign m1_bus.ack     = m1_ack_s;
    assign m1_bus.dat_r   = m1_dat_s;

    // Grant is decoded from the registered state; an illegal state reads idle.
    assign Grant_o   = {(state_q == ST_GNT1), (state_q == ST_GNT0)};
    assign Timeout_o = timeout_fire_s;

endmodule
